// File: rtl/ram_bus_pkg.sv
// Shared RamBus master definitions: default bus widths, FSM states, error word and wait-counter width.
package ram_bus_pkg;

    localparam int          ADDR_WIDTH_DEF = 14;
    localparam int          DATA_WIDTH_DEF = 32;
    localparam int          WAIT_CNT_WIDTH = 16;
    localparam logic [31:0] ERR_DATA_DEF   = 32'hDEAD_0BAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_bus_master_wait_timer.sv
// Wait-state counter: clear/increment, saturates at all-ones; expired_o is a pure function of the registered count.
// A zero limit never expires, which is how the timeout is disabled.
module bus_wait_timer
    import ram_bus_pkg::*;
(
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      clr_i,
    input  logic                      inc_i,
    input  logic [WAIT_CNT_WIDTH-1:0] limit_i,
    output logic                      expired_o
);

    logic [WAIT_CNT_WIDTH-1:0] cnt_q;
    logic [WAIT_CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WAIT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is zero in the first ACCESS cycle, so limit-1 marks the last allowed wait cycle.
    assign expired_o = (limit_i != '0) && (cnt_q == (limit_i - WAIT_CNT_WIDTH'(1)));

endmodule

// File: rtl/ram_bus_master.sv
// Single-beat RamBus (APB3-style) initiator: 4 cycles per transaction plus one per wait state, bounded by a timeout.
// Commands are accepted only in IDLE and never buffered; the response is held until RspReady.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEF)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrnRd,
    input  logic [ADDR_WIDTH-1:0] CmdAddress,
    input  logic [DATA_WIDTH-1:0] CmdData,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspData,
    output logic                  RspError,
    output logic                  RamBusSel,
    output logic                  RamBusLatch,
    output logic                  RamBusWrnRd,
    output logic [ADDR_WIDTH-1:0] RamBusAddress,
    output logic [DATA_WIDTH-1:0] RamBusDataOut,
    input  logic [DATA_WIDTH-1:0] RamBusDataIn,
    input  logic                  RamBusAck
);

    localparam logic [WAIT_CNT_WIDTH-1:0] TMR_LIMIT = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES);

    state_e                state_q;
    state_e                state_d;
    logic                  cmd_rdy_q;
    logic                  sel_q;
    logic                  latch_q;
    logic                  rsp_vld_q;
    logic                  rsp_err_q;
    logic                  rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q;
    logic [DATA_WIDTH-1:0] rsp_dat_d;
    logic                  wr_q;
    logic                  wr_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] wdat_d;
    logic                  tmr_clr;
    logic                  tmr_inc;
    logic                  tmr_expired;

    bus_wait_timer u_wait_timer (
        .clk       (clk),
        .nRst      (nRst),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .limit_i   (TMR_LIMIT),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CmdValid) begin
                    wr_d    = CmdWrnRd;
                    addr_d  = CmdAddress;
                    wdat_d  = CmdData;
                    tmr_clr = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Ack has priority over an expiry in the same cycle.
                if (RamBusAck) begin
                    rsp_dat_d = wr_q ? '0 : RamBusDataIn;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (tmr_expired) begin
                    rsp_dat_d = ERR_DATA;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake/strobe outputs are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            cmd_rdy_q <= 1'b1;
            sel_q     <= 1'b0;
            latch_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= (state_d == ST_IDLE);
            sel_q     <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            latch_q   <= (state_d == ST_ACCESS);
            rsp_vld_q <= (state_d == ST_RESP);
            rsp_err_q <= rsp_err_d;
            rsp_dat_q <= rsp_dat_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
        end
    end

    assign CmdReady      = cmd_rdy_q;
    assign RspValid      = rsp_vld_q;
    assign RspData       = rsp_dat_q;
    assign RspError      = rsp_err_q;
    assign RamBusSel     = sel_q;
    assign RamBusLatch   = latch_q;
    assign RamBusWrnRd   = wr_q;
    assign RamBusAddress = addr_q;
    assign RamBusDataOut = wdat_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: transaction-level model predicts every output each cycle; a slave model inserts wait states.
module tb_ram_bus_master;

    localparam int          AW  = 14;
    localparam int          DW  = 32;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_0BAD;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          CmdValid = 1'b0;
    logic          CmdReady;
    logic          CmdWrnRd = 1'b0;
    logic [AW-1:0] CmdAddress = '0;
    logic [DW-1:0] CmdData = '0;
    logic          RspValid;
    logic          RspReady = 1'b0;
    logic [DW-1:0] RspData;
    logic          RspError;
    logic          RamBusSel;
    logic          RamBusLatch;
    logic          RamBusWrnRd;
    logic [AW-1:0] RamBusAddress;
    logic [DW-1:0] RamBusDataOut;
    logic [DW-1:0] RamBusDataIn = '0;
    logic          RamBusAck = 1'b0;

    ram_bus_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .CmdValid      (CmdValid),
        .CmdReady      (CmdReady),
        .CmdWrnRd      (CmdWrnRd),
        .CmdAddress    (CmdAddress),
        .CmdData       (CmdData),
        .RspValid      (RspValid),
        .RspReady      (RspReady),
        .RspData       (RspData),
        .RspError      (RspError),
        .RamBusSel     (RamBusSel),
        .RamBusLatch   (RamBusLatch),
        .RamBusWrnRd   (RamBusWrnRd),
        .RamBusAddress (RamBusAddress),
        .RamBusDataOut (RamBusDataOut),
        .RamBusDataIn  (RamBusDataIn),
        .RamBusAck     (RamBusAck)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        chk(nm, 32'(act), 32'(exp));
    endfunction

    // Plan for the next command: how many ACCESS cycles the slave stalls and what it returns.
    int          p_waits = 0;
    logic [31:0] p_rdata = '0;

    // Transaction model: m_d counts edges since acceptance; a transaction spends
    // one SETUP cycle and m_A ACCESS cycles on the bus before its response appears.
    bit          m_busy = 1'b0;
    bit          m_rsp = 1'b0;
    int          m_d = 0;
    int          m_A = 0;
    int          m_waits = 0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_nxt_data = '0;
    bit          m_err = 1'b0;
    bit          m_nxt_err = 1'b0;
    logic        m_wr = 1'b0;
    logic [13:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_busy = 1'b0; m_rsp = 1'b0; m_d = 0; m_A = 0;
            m_data = '0; m_err = 1'b0;
            m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (m_rsp) begin
            if (RspReady) m_rsp = 1'b0;
        end else if (m_busy) begin
            m_d++;
            if (m_d > m_A) begin
                m_busy = 1'b0;
                m_rsp  = 1'b1;
                m_data = m_nxt_data;
                m_err  = m_nxt_err;
            end
        end else if (CmdValid) begin
            m_busy  = 1'b1;
            m_d     = 0;
            m_wr    = CmdWrnRd;
            m_addr  = CmdAddress;
            m_wdata = CmdData;
            m_waits = p_waits;
            m_rdata = p_rdata;
            if (p_waits < TO) begin
                m_A        = p_waits + 1;
                m_nxt_err  = 1'b0;
                m_nxt_data = CmdWrnRd ? 32'd0 : p_rdata;
            end else begin
                m_A        = TO;
                m_nxt_err  = 1'b1;
                m_nxt_data = ERR;
            end
        end
    end

    // Slave: stalls m_waits ACCESS cycles then acks; outside ACCESS it drives random Ack noise.
    int acc_seen = 0;
    always @(negedge clk) begin
        if (RamBusSel && RamBusLatch) begin
            acc_seen++;
            if (acc_seen >= m_waits + 1) begin
                RamBusAck    = 1'b1;
                RamBusDataIn = m_rdata;
            end else begin
                RamBusAck    = 1'b0;
                RamBusDataIn = $urandom;
            end
        end else begin
            acc_seen     = 0;
            RamBusAck    = 1'($urandom_range(0, 1));
            RamBusDataIn = $urandom;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("CmdReady", CmdReady, !m_busy && !m_rsp);
            chk1("RamBusSel", RamBusSel, m_busy);
            chk1("RamBusLatch", RamBusLatch, m_busy && (m_d >= 1));
            chk1("RspValid", RspValid, m_rsp);
            chk("RspData", RspData, m_data);
            chk1("RspError", RspError, m_err);
            chk1("RamBusWrnRd", RamBusWrnRd, m_wr);
            chk("RamBusAddress", 32'(RamBusAddress), 32'(m_addr));
            chk("RamBusDataOut", RamBusDataOut, m_wdata);
        end
    end

    // Called at a negedge; returns at the negedge right after the response handshake edge.
    task automatic do_txn(input bit wr, input logic [13:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input int hold_lo, input bit keep,
                          output logic [31:0] r_dat, output bit r_err, output int lat,
                          output int latches, output logic [13:0] a_seen, output bit wr_seen,
                          output int rdy_hi);
        int n;
        int acc_c;
        p_waits = waits; p_rdata = rd;
        CmdWrnRd = wr; CmdAddress = a; CmdData = wd; CmdValid = 1'b1;
        n = 0;
        while (!CmdReady && n < 50) begin @(negedge clk); n++; end
        chk1("accept_wait", CmdReady, 1'b1);
        @(negedge clk);
        acc_c = cyc;
        if (!keep) CmdValid = 1'b0;
        latches = 0; a_seen = '0; wr_seen = 1'b0; n = 0;
        while (!RspValid && n < 200) begin
            if (RamBusLatch) begin
                latches++;
                a_seen  = RamBusAddress;
                wr_seen = RamBusWrnRd;
            end
            @(negedge clk);
            n++;
        end
        chk1("rsp_wait", RspValid, 1'b1);
        lat = cyc - acc_c; r_dat = RspData; r_err = RspError;
        rdy_hi = 0;
        repeat (hold_lo) begin
            @(negedge clk);
            if (CmdReady) rdy_hi++;
        end
        RspReady = 1'b1;
        @(negedge clk);
        RspReady = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r_dat;
        bit          r_err;
        int          lat;
        int          latches;
        logic [13:0] a_seen;
        bit          wr_seen;
        int          rdy_hi;
        int          n;

        repeat (3) @(negedge clk);
        chk1("reset_CmdReady", CmdReady, 1'b1);
        chk1("reset_Sel", RamBusSel, 1'b0);
        chk1("reset_RspValid", RspValid, 1'b0);
        chk("reset_RspData", RspData, 32'd0);
        chk("reset_Address", 32'(RamBusAddress), 32'd0);
        nRst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Write with immediate ack: response two edges after the accept edge.
        do_txn(1'b1, 14'h0040, 32'h1234_5678, 0, 32'h0, 0, 1'b0,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("wr_latency", lat, 32'd2);
        chk("wr_access_cycles", latches, 32'd1);
        chk("wr_RspData", r_dat, 32'd0);
        chk1("wr_RspError", r_err, 1'b0);
        chk("wr_address", 32'(a_seen), 32'h40);
        chk1("wr_WrnRd", wr_seen, 1'b1);

        // Read with 3 wait states.
        do_txn(1'b0, 14'h1FFC, 32'h0, 3, 32'hCAFE_F00D, 0, 1'b0,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("rd3_latency", lat, 32'd5);
        chk("rd3_access_cycles", latches, 32'd4);
        chk("rd3_RspData", r_dat, 32'hCAFE_F00D);
        chk1("rd3_RspError", r_err, 1'b0);

        // Slave never acks: timeout after exactly TO ACCESS cycles.
        do_txn(1'b0, 14'h0123, 32'h0, 1000, 32'h1111_2222, 0, 1'b0,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("to_access_cycles", latches, 32'd8);
        chk("to_latency", lat, 32'd9);
        chk("to_RspData", r_dat, 32'hDEAD_0BAD);
        chk1("to_RspError", r_err, 1'b1);
        chk1("to_Sel_after", RamBusSel, 1'b0);

        // Ack lands on the final allowed ACCESS cycle: ack wins over the timeout.
        do_txn(1'b0, 14'h0200, 32'h0, TO - 1, 32'h5A5A_1234, 0, 1'b0,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("edge_access_cycles", latches, 32'd8);
        chk("edge_RspData", r_dat, 32'h5A5A_1234);
        chk1("edge_RspError", r_err, 1'b0);

        // Response held 10 cycles with CmdValid kept high.
        do_txn(1'b0, 14'h0300, 32'h0, 1, 32'h0BAD_CAFE, 10, 1'b1,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("hold_CmdReady_high_cycles", rdy_hi, 32'd0);
        chk("hold_RspData", r_dat, 32'h0BAD_CAFE);

        for (int i = 0; i < 200; i++) begin
            int w;
            case ($urandom_range(0, 7))
                0: w = 0;
                1: w = 1;
                2: w = 2;
                3: w = 3;
                4: w = TO - 2;
                5: w = TO - 1;
                6: w = TO;
                default: w = TO + 5;
            endcase
            do_txn(1'($urandom_range(0, 1)), 14'($urandom), $urandom, w, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                   r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        end
        CmdValid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of ACCESS.
        p_waits = 1000; p_rdata = 32'h0;
        CmdWrnRd = 1'b1; CmdAddress = 14'h2AAA; CmdData = 32'h7777_8888; CmdValid = 1'b1;
        n = 0;
        while (!CmdReady && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        CmdValid = 1'b0;
        n = 0;
        while (!RamBusLatch && n < 20) begin @(negedge clk); n++; end
        chk1("rst_in_access", RamBusLatch, 1'b1);
        @(negedge clk);
        #1 nRst = 1'b0;
        #1;
        chk1("rst_Sel_immediate", RamBusSel, 1'b0);
        chk1("rst_Latch_immediate", RamBusLatch, 1'b0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        chk1("postrst_CmdReady", CmdReady, 1'b1);
        chk1("postrst_RspValid", RspValid, 1'b0);
        chk("postrst_Address", 32'(RamBusAddress), 32'd0);
        chk("postrst_DataOut", RamBusDataOut, 32'd0);
        chk1("postrst_WrnRd", RamBusWrnRd, 1'b0);

        do_txn(1'b0, 14'h0010, 32'h0, 2, 32'h1357_9BDF, 0, 1'b0,
               r_dat, r_err, lat, latches, a_seen, wr_seen, rdy_hi);
        chk("postrst_rd_RspData", r_dat, 32'h1357_9BDF);
        chk("postrst_rd_latency", lat, 32'd4);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Fabric-side initiator for the RamBus (APB3-style) slave port that DMMainPorts exposes. It converts single-beat read/write commands from fabric logic, such as a UART command parser or self-test sequencer, into SETUP/ACCESS bus cycles. It returns read data or a timeout error through a held response handshake. A hung slave cannot stall the fabric: a bounded wait produces an error response instead.

## Interface
- ADDR_WIDTH, 14, RamBus address width.
- DATA_WIDTH, 32, RamBus data width.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles to wait for RamBusAck; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_0BAD, value driven on RspData when a timeout occurs.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- nRst  in  1  asynchronous active-low reset.
- CmdValid  in  1  command request.
- CmdReady  out  1  command accepted when CmdValid && CmdReady.
- CmdWrnRd  in  1  1 = write, 0 = read.
- CmdAddress  in  ADDR_WIDTH  target address.
- CmdData  in  DATA_WIDTH  write data; ignored on reads.
- RspValid  out  1  response available; held until accepted.
- RspReady  in  1  response consumed when RspValid && RspReady.
- RspData  out  DATA_WIDTH  read data; 0 for a successful write; ERR_DATA on timeout.
- RspError  out  1  1 = timeout.
- RamBusSel  out  1  APB PSEL, active high.
- RamBusLatch  out  1  APB PENABLE.
- RamBusWrnRd  out  1  APB PWRITE.
- RamBusAddress  out  ADDR_WIDTH  APB PADDR.
- RamBusDataOut  out  DATA_WIDTH  APB PWDATA.
- RamBusDataIn  in  DATA_WIDTH  APB PRDATA.
- RamBusAck  in  1  APB PREADY.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - CmdReady=1.
  - On CmdValid: capture CmdWrnRd/CmdAddress/CmdData into the bus output registers, clear the wait counter, go to SETUP.
- SETUP
  - RamBusSel=1, RamBusLatch=0.
  - Unconditionally go to ACCESS.
- ACCESS
  - RamBusSel=1, RamBusLatch=1.
  - If RamBusAck:
    - read: RspData<=RamBusDataIn.
    - write: RspData<=0.
    - RspError<=0; go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and the wait counter equals TIMEOUT_CYCLES-1: RspData<=ERR_DATA, RspError<=1, go to RESP.
  - Else the wait counter increments.
- RESP
  - RspValid=1; RamBusSel=RamBusLatch=0.
  - On RspReady go to IDLE.
- Boundary rules:
  - RamBusAck and the timeout in the same cycle: Ack wins, RspError=0.
  - RamBusAck is ignored outside ACCESS.
  - The wait counter is 16 bits and saturates; TIMEOUT_CYCLES must be ≤ 65535.
  - CmdReady=0 in every state except IDLE; commands are never dropped and never buffered.
  - RamBusAddress, RamBusWrnRd and RamBusDataOut are stable from SETUP through the final ACCESS cycle.
  - In IDLE and RESP these outputs hold their last values; only Sel and Latch return to 0.
  - RspData and RspError hold from RESP entry until the next response is loaded.

## Timing
- Reset values: state=IDLE, CmdReady=1, RspValid=0, RspError=0, RspData=0, RamBusSel=0, RamBusLatch=0, RamBusWrnRd=0, RamBusAddress=0, RamBusDataOut=0, wait counter=0.
- Reset mid-transaction drops RamBusSel/RamBusLatch immediately (asynchronous); the pending response is discarded.
- Accept at edge N: SETUP in cycle N+1, ACCESS from N+2.
- With Ack in the first ACCESS cycle: RspValid rises at N+3.
- With RspReady high: IDLE at N+4, so back-to-back throughput is 1 transaction per 4 cycles.
- Each additional wait-state cycle adds one cycle of latency.
- Timeout: RspValid rises TIMEOUT_CYCLES cycles after ACCESS entry, with RspError=1.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package ram_bus_pkg holds:
  - default ADDR_WIDTH and DATA_WIDTH;
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the ERR_DATA constant;
  - the wait-counter width (16).
- One natural sub-module, bus_wait_timer: 16-bit clear/increment/saturate counter that outputs an expired flag for a programmable limit; limit 0 means never expires.
- The FSM and output registers stay in ram_bus_master.

## Test plan
- Write 0x12345678 to 0x0040 with Ack held high:
  - Sel rises N+1, Latch N+2, RspValid N+3;
  - RspData=0, RspError=0;
  - bus address 0x0040, WrnRd=1 stable across both phases.
- Read 0x1FFC while the slave inserts 3 wait states and then returns 0xCAFEF00D:
  - RspValid at N+6;
  - RspData=0xCAFEF00D, RspError=0.
- TIMEOUT_CYCLES=8 with Ack never asserted:
  - exactly 8 ACCESS cycles;
  - RspError=1, RspData=0xDEAD0BAD;
  - Sel=0 after.
- Ack coincides with the final timeout cycle (TIMEOUT_CYCLES=4, Ack on the 4th ACCESS cycle) -> RspError=0 and read data is returned.
- Hold RspReady low 10 cycles with CmdValid continuously high:
  - CmdReady stays 0 and RspValid/RspData stay stable;
  - the next command is accepted only after the handshake.
- Assert nRst low during ACCESS:
  - Sel/Latch go 0 in the same cycle;
  - after release, all outputs are at their reset values and CmdReady=1.
